// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 16 lines of 128 bits; address split is tag [31:8], index [7:4], word [3:2].
//
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   cpu_read, cpu_write   - CPU load/store request, held until cpu_stall is low
//   cpu_address           - CPU byte address
//   cpu_write_data        - store word
//   cpu_read_data         - load word, valid on a read hit
//   cpu_stall             - request cannot complete this cycle
//   mem_read, mem_write   - block refill / writeback requests to memory
//   mem_read_address      - refill line address
//   mem_write_address     - victim line address
//   mem_write_data        - victim line, word 0 in [31:0]
//   mem_read_data         - refill line, word 0 in [31:0]
//   mem_read_valid        - one-cycle pulse: refill data present
//   mem_write_done        - one-cycle pulse: writeback committed
module data_cache_ctrl #(
    parameter int unsigned NUM_LINES = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [31:0]  cpu_address,
    input  logic [31:0]  cpu_write_data,
    output logic [31:0]  cpu_read_data,
    output logic         cpu_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_read_address,
    output logic [31:0]  mem_write_address,
    output logic [127:0] mem_write_data,
    input  logic [127:0] mem_read_data,
    input  logic         mem_read_valid,
    input  logic         mem_write_done
);

    typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_t;

    state_t         state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [23:0]    tag_q  [NUM_LINES];
    logic [127:0]   data_q [NUM_LINES];
    // Line address (tag + index) of the miss being serviced.
    logic [27:0]    miss_addr_q;

    logic [23:0] tag;
    logic [3:0]  index;
    logic [1:0]  word;
    logic [3:0]  miss_index;
    logic        req;
    logic        hit;
    logic        unused_byte_bits;

    assign tag              = cpu_address[31:8];
    assign index            = cpu_address[7:4];
    assign word             = cpu_address[3:2];
    assign unused_byte_bits = ^cpu_address[1:0];
    assign miss_index       = miss_addr_q[3:0];

    assign req = cpu_read | cpu_write;
    assign hit = req & valid_q[index] & (tag_q[index] == tag);

    always_comb begin
        cpu_stall = 1'b1;
        if (state_q == StIdle) begin
            cpu_stall = req & ~hit;
        end
    end

    assign cpu_read_data     = data_q[index][{word, 5'b0} +: 32];
    // Addresses come from the latched miss so they stay stable for the whole transaction.
    assign mem_read_address  = {miss_addr_q, 4'b0000};
    assign mem_write_address = {tag_q[miss_index], miss_index, 4'b0000};
    assign mem_write_data    = data_q[miss_index];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            miss_addr_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A combined read+write is handled as a write.
                    if (hit && cpu_write) begin
                        data_q[index][{word, 5'b0} +: 32] <= cpu_write_data;
                        dirty_q[index] <= 1'b1;
                    end else if (req && !hit) begin
                        miss_addr_q <= cpu_address[31:4];
                        if (valid_q[index] && dirty_q[index]) begin
                            state_q   <= StWriteback;
                            mem_write <= 1'b1;
                        end else begin
                            state_q  <= StRefill;
                            mem_read <= 1'b1;
                        end
                    end
                end
                StWriteback: begin
                    if (mem_write_done) begin
                        mem_write           <= 1'b0;
                        dirty_q[miss_index] <= 1'b0;
                        // mem_write falls on the same edge, so the two never overlap.
                        mem_read            <= 1'b1;
                        state_q             <= StRefill;
                    end
                end
                StRefill: begin
                    if (mem_read_valid) begin
                        data_q[miss_index]  <= mem_read_data;
                        tag_q[miss_index]   <= miss_addr_q[27:4];
                        valid_q[miss_index] <= 1'b1;
                        dirty_q[miss_index] <= 1'b0;
                        mem_read            <= 1'b0;
                        // The held request re-evaluates as a hit in idle.
                        state_q             <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
module tb_data_cache_ctrl;

    localparam int RD_LAT = 10;
    localparam int WR_LAT = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_address;
    logic [31:0]  cpu_write_data;
    logic [31:0]  cpu_read_data;
    logic         cpu_stall;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_read_address;
    logic [31:0]  mem_write_address;
    logic [127:0] mem_write_data;
    logic [127:0] mem_read_data;
    logic         mem_read_valid;
    logic         mem_write_done;

    logic         resp_valid = 1'b0;
    logic         resp_done  = 1'b0;
    logic [127:0] resp_data  = '0;
    logic         spur_valid = 1'b0;
    logic         spur_done  = 1'b0;

    assign mem_read_valid = resp_valid | spur_valid;
    assign mem_write_done = resp_done | spur_done;
    assign mem_read_data  = spur_valid ? {128{1'b1}} : resp_data;

    always #5 clock = ~clock;

    data_cache_ctrl #(.NUM_LINES(16)) dut (
        .clock             (clock),
        .reset             (reset),
        .cpu_read          (cpu_read),
        .cpu_write         (cpu_write),
        .cpu_address       (cpu_address),
        .cpu_write_data    (cpu_write_data),
        .cpu_read_data     (cpu_read_data),
        .cpu_stall         (cpu_stall),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_read_address  (mem_read_address),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data),
        .mem_read_valid    (mem_read_valid),
        .mem_write_done    (mem_write_done)
    );

    // Backing memory, keyed by line address.
    logic [127:0] mem [logic [27:0]];

    function automatic logic [127:0] line_of(input logic [27:0] a);
        logic [127:0] l;
        if (mem.exists(a)) begin
            l = mem[a];
        end else begin
            for (int k = 0; k < 4; k++) begin
                l[k*32 +: 32] = 32'hA500_0000 | {a, 4'b0000} | (k << 2);
            end
        end
        return l;
    endfunction

    // Read responder: refill pulse RD_LAT cycles after mem_read is seen.
    initial begin
        logic [27:0] a;
        forever begin
            @(posedge clock);
            #1;
            if (mem_read) begin
                a = mem_read_address[31:4];
                repeat (RD_LAT - 1) @(posedge clock);
                #1;
                resp_data  = line_of(a);
                resp_valid = 1'b1;
                @(posedge clock);
                #1;
                resp_valid = 1'b0;
            end
        end
    end

    // Write responder: also owns the memory preload.
    initial begin
        mem[28'h4] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        forever begin
            @(posedge clock);
            #1;
            if (mem_write) begin
                mem[mem_write_address[31:4]] = mem_write_data;
                repeat (WR_LAT - 1) @(posedge clock);
                #1;
                resp_done = 1'b1;
                @(posedge clock);
                #1;
                resp_done = 1'b0;
            end
        end
    end

    // Bus monitor: counts request rising edges and read/write overlap.
    int           rd_rises = 0;
    int           wr_rises = 0;
    int           overlap  = 0;
    logic         prev_rd  = 1'b0;
    logic         prev_wr  = 1'b0;
    logic [31:0]  last_rd_addr = '0;
    logic [31:0]  last_wr_addr = '0;
    logic [127:0] last_wr_line = '0;

    always @(negedge clock) begin
        if (mem_read && !prev_rd) begin
            rd_rises     <= rd_rises + 1;
            last_rd_addr <= mem_read_address;
        end
        if (mem_write && !prev_wr) begin
            wr_rises     <= wr_rises + 1;
            last_wr_addr <= mem_write_address;
            last_wr_line <= mem_write_data;
        end
        if (mem_read && mem_write) overlap <= overlap + 1;
        prev_rd <= mem_read;
        prev_wr <= mem_write;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts at posedge+1, holds the request until cpu_stall is low, releases after that edge.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata,
                             output int stalls, output logic timed_out);
        cpu_read       = rd;
        cpu_write      = wr;
        cpu_address    = addr;
        cpu_write_data = wdata;
        stalls         = 0;
        timed_out      = 1'b0;
        #1;
        while (cpu_stall) begin
            stalls++;
            if (stalls > 300) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clock);
            #2;
        end
        rdata = cpu_read_data;
        @(posedge clock);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [31:0]  exp_rdata;
        int           exp_stall;
        int           exp_rd;
        int           exp_wr;
        logic [31:0]  exp_rd_addr;
        logic [31:0]  exp_wr_addr;
        logic [127:0] exp_wr_line;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input int exp_stall, input int exp_rd, input int exp_wr,
                                input logic [31:0] exp_rd_addr, input logic [31:0] exp_wr_addr,
                                input logic [127:0] exp_wr_line);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
        v.exp_stall = exp_stall; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
        v.exp_rd_addr = exp_rd_addr; v.exp_wr_addr = exp_wr_addr; v.exp_wr_line = exp_wr_line;
        return v;
    endfunction

    function automatic vec_t rd_v(input logic [31:0] addr, input logic [31:0] exp,
                                  input int stall, input int nrd, input logic [31:0] rd_addr);
        return mk(1'b1, 1'b0, addr, 32'h0, exp, stall, nrd, 0, rd_addr, 32'h0, 128'h0);
    endfunction

    vec_t vecs [16];

    task automatic run_vec(input string tag, input vec_t v);
        logic [31:0] rdata;
        int          stalls;
        logic        to;
        int          rd0;
        int          wr0;
        rd0 = rd_rises;
        wr0 = wr_rises;
        do_access(v.rd, v.wr, v.addr, v.wdata, rdata, stalls, to);
        chk({tag, "_timeout"}, to, 1'b0);
        chk({tag, "_stall_cycles"}, stalls, v.exp_stall);
        chk({tag, "_mem_reads"}, rd_rises - rd0, v.exp_rd);
        chk({tag, "_mem_writes"}, wr_rises - wr0, v.exp_wr);
        if (v.exp_rd > 0) chk({tag, "_rd_addr"}, last_rd_addr, v.exp_rd_addr);
        if (v.exp_wr > 0) begin
            chk({tag, "_wr_addr"}, last_wr_addr, v.exp_wr_addr);
            chk({tag, "_wr_line"}, last_wr_line, v.exp_wr_line);
        end
        if (v.rd && !v.wr) chk({tag, "_rdata"}, rdata, v.exp_rdata);
    endtask

    initial begin
        vecs[0]  = rd_v(32'h40, 32'h1111_1111, 11, 1, 32'h40);
        vecs[1]  = rd_v(32'h44, 32'h2222_2222, 0, 0, 32'h0);
        vecs[2]  = mk(1'b0, 1'b1, 32'h48, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 32'h0, 32'h0, 128'h0);
        vecs[3]  = rd_v(32'h48, 32'hDEAD_BEEF, 0, 0, 32'h0);
        vecs[4]  = rd_v(32'h4F, 32'h4444_4444, 0, 0, 32'h0);
        vecs[5]  = mk(1'b1, 1'b0, 32'h140, 32'h0, 32'hA500_0140, 16, 1, 1, 32'h140, 32'h40,
                      128'h4444_4444_DEAD_BEEF_2222_2222_1111_1111);
        vecs[6]  = rd_v(32'h48, 32'hDEAD_BEEF, 11, 1, 32'h40);
        vecs[7]  = mk(1'b0, 1'b1, 32'h200, 32'h1234_5678, 32'h0, 11, 1, 0, 32'h200, 32'h0,
                      128'h0);
        vecs[8]  = rd_v(32'h200, 32'h1234_5678, 0, 0, 32'h0);
        vecs[9]  = rd_v(32'h204, 32'hA500_0204, 0, 0, 32'h0);
        vecs[10] = mk(1'b1, 1'b1, 32'h208, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 32'h0, 32'h0, 128'h0);
        vecs[11] = rd_v(32'h208, 32'hCAFE_F00D, 0, 0, 32'h0);
        vecs[12] = rd_v(32'h310, 32'hA500_0310, 11, 1, 32'h310);
        vecs[13] = rd_v(32'h520, 32'hA500_0520, 11, 1, 32'h520);
        vecs[14] = mk(1'b0, 1'b1, 32'h300, 32'h0BAD_C0DE, 32'h0, 16, 1, 1, 32'h300, 32'h200,
                      128'hA500_020C_CAFE_F00D_A500_0204_1234_5678);
        vecs[15] = rd_v(32'h300, 32'h0BAD_C0DE, 0, 0, 32'h0);

        reset          = 1'b1;
        cpu_read       = 1'b0;
        cpu_write      = 1'b0;
        cpu_address    = '0;
        cpu_write_data = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_idle_stall", cpu_stall, 1'b0);
        @(posedge clock);
        #1;

        for (int i = 0; i < 16; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Stray memory pulses while idle must not touch the array.
        spur_valid = 1'b1;
        spur_done  = 1'b1;
        #1;
        chk("spur_idle_stall", cpu_stall, 1'b0);
        @(posedge clock);
        #1;
        spur_valid = 1'b0;
        spur_done  = 1'b0;
        run_vec("spur_after", rd_v(32'h300, 32'h0BAD_C0DE, 0, 0, 32'h0));

        // Reset in the middle of a refill abandons it.
        cpu_read    = 1'b1;
        cpu_address = 32'h730;
        repeat (4) @(posedge clock);
        #1;
        chk("mid_refill_mem_read", mem_read, 1'b1);
        chk("mid_refill_stall", cpu_stall, 1'b1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_refill_mem_read", mem_read, 1'b0);
        chk("rst_refill_mem_write", mem_write, 1'b0);
        reset    = 1'b0;
        cpu_read = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        run_vec("post_rst_300", rd_v(32'h300, 32'hA500_0300, 11, 1, 32'h300));
        run_vec("post_rst_730", rd_v(32'h730, 32'hA500_0730, 11, 1, 32'h730));

        chk("rd_wr_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
